// File: rtl/tlb_walker.sv
// tlb_walker: page-table walker shared by the I- and D-TLB. Round-robin grant of
// one miss at a time, single outstanding PTE read, then a TLB refill or a page fault.
module tlb_walker #(
  parameter logic [19:0] PT_BASE = 20'h00000,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             itlb_miss,
  input  logic [19:0]      itlb_vpn,
  input  logic             dtlb_miss,
  input  logic [19:0]      dtlb_vpn,
  output logic             mem_req,
  output logic [19:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic             itlb_write_en,
  output logic             dtlb_write_en,
  output logic [19:0]      write_vpn,
  output logic [7:0]       write_ppn,
  output logic             fault,
  output logic             fault_is_d,
  output logic [19:0]      fault_vpn,
  output logic             busy,
  output logic [CNT_W-1:0] walk_cnt,
  output logic [CNT_W-1:0] fault_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WALK  = 2'd1,
    FILL  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic        cur_d_r;
  logic        last_d_r;
  logic        mask_i_r;
  logic        mask_d_r;
  logic [19:0] cur_vpn_r;
  logic        elig_i_s;
  logic        elig_d_s;
  logic        grant_s;
  logic        grant_d_s;
  logic        pte_ok_s;
  logic        pte_bad_s;
  logic [19:0] pte_off_s;
  logic        unused_bits_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // The offset keeps only 20 bits so the table address wraps without error.
  assign pte_off_s     = {cur_vpn_r[17:0], 2'b00};
  assign mem_req       = (state_r == WALK);
  assign mem_addr      = mem_req ? (PT_BASE + pte_off_s) : 20'h00000;
  assign busy          = (state_r != IDLE);
  assign unused_bits_s = ^{mem_rdata[30:8], cur_vpn_r[19:18]};

  // Next-state decode, arbitration and PTE classification.
  always_comb begin
    state_s   = state_r;
    grant_s   = 1'b0;
    grant_d_s = 1'b0;
    pte_ok_s  = 1'b0;
    pte_bad_s = 1'b0;
    elig_i_s  = itlb_miss & ~mask_i_r;
    elig_d_s  = dtlb_miss & ~mask_d_r;
    case (state_r)
      IDLE: begin
        if (elig_i_s || elig_d_s) begin
          grant_s   = 1'b1;
          grant_d_s = (elig_i_s && elig_d_s) ? ~last_d_r : elig_d_s;
          state_s   = WALK;
        end else begin
          state_s = IDLE;
        end
      end
      WALK: begin
        if (mem_ack) begin
          if (mem_rdata[31]) begin
            pte_ok_s = 1'b1;
            state_s  = FILL;
          end else begin
            pte_bad_s = 1'b1;
            state_s   = FAULT;
          end
        end else begin
          state_s = WALK;
        end
      end
      FILL:    state_s = IDLE;
      FAULT:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register, grant bookkeeping and stale-miss masks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cur_d_r   <= 1'b0;
      cur_vpn_r <= 20'h00000;
      last_d_r  <= 1'b1;
      mask_i_r  <= 1'b0;
      mask_d_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      if (grant_s) begin
        cur_d_r   <= grant_d_s;
        cur_vpn_r <= grant_d_s ? dtlb_vpn : itlb_vpn;
        last_d_r  <= grant_d_s;
      end
      if (state_r == IDLE) begin
        if (grant_s) begin
          mask_i_r <= 1'b0;
          mask_d_r <= 1'b0;
        end else begin
          if (!itlb_miss) mask_i_r <= 1'b0;
          if (!dtlb_miss) mask_d_r <= 1'b0;
        end
      end else if ((state_r == FILL) || (state_r == FAULT)) begin
        if (cur_d_r) mask_d_r <= 1'b1;
        else         mask_i_r <= 1'b1;
      end
    end
  end

  // Refill and fault outputs, registered off the acknowledged PTE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      itlb_write_en <= 1'b0;
      dtlb_write_en <= 1'b0;
      write_vpn     <= 20'h00000;
      write_ppn     <= 8'h00;
      fault         <= 1'b0;
      fault_is_d    <= 1'b0;
      fault_vpn     <= 20'h00000;
    end else begin
      itlb_write_en <= pte_ok_s & ~cur_d_r;
      dtlb_write_en <= pte_ok_s & cur_d_r;
      fault         <= pte_bad_s;
      if (pte_ok_s) begin
        write_vpn <= cur_vpn_r;
        write_ppn <= mem_rdata[7:0];
      end
      if (pte_bad_s) begin
        fault_is_d <= cur_d_r;
        fault_vpn  <= cur_vpn_r;
      end
    end
  end

  // Saturating statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      walk_cnt  <= {CNT_W{1'b0}};
      fault_cnt <= {CNT_W{1'b0}};
    end else begin
      if ((state_r == FILL) || (state_r == FAULT)) walk_cnt <= sat_inc(walk_cnt);
      if (state_r == FAULT) fault_cnt <= sat_inc(fault_cnt);
    end
  end

endmodule

// File: tb/tb_tlb_walker.sv
// Scoreboard bench for tlb_walker: TLB-side drivers push expected refills/faults,
// a memory responder serves a page-table model, and a monitor pops and compares.
module tb_tlb_walker;
  localparam logic [19:0] PT_BASE = 20'h10000;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             itlb_miss, dtlb_miss;
  logic [19:0]      itlb_vpn, dtlb_vpn;
  logic             mem_req, mem_ack;
  logic [19:0]      mem_addr;
  logic [31:0]      mem_rdata;
  logic             itlb_write_en, dtlb_write_en, fault, fault_is_d, busy;
  logic [19:0]      write_vpn, fault_vpn;
  logic [7:0]       write_ppn;
  logic [CNT_W-1:0] walk_cnt, fault_cnt;

  tlb_walker #(.PT_BASE(PT_BASE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .itlb_miss(itlb_miss), .itlb_vpn(itlb_vpn),
    .dtlb_miss(dtlb_miss), .dtlb_vpn(dtlb_vpn),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .itlb_write_en(itlb_write_en), .dtlb_write_en(dtlb_write_en),
    .write_vpn(write_vpn), .write_ppn(write_ppn),
    .fault(fault), .fault_is_d(fault_is_d), .fault_vpn(fault_vpn),
    .busy(busy), .walk_cnt(walk_cnt), .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_fault;
    logic [19:0] vpn;
    logic [7:0]  ppn;
  } exp_t;

  exp_t        exp_q0[$];
  exp_t        exp_q1[$];
  int          served_log[$];
  logic [31:0] pt [logic [19:0]];
  logic        miss_a[2];
  logic [19:0] vpn_a[2];
  int          st[2];
  int          age[2];
  int          n_vec = 0, n_err = 0, n_raised = 0, n_faults = 0;
  int          force_hold = -1, force_delay = -1;
  logic        gen_en = 1'b0, mem_hold = 1'b0;

  assign itlb_miss = miss_a[0];
  assign dtlb_miss = miss_a[1];
  assign itlb_vpn  = vpn_a[0];
  assign dtlb_vpn  = vpn_a[1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int req);
    n_vec++;
    n_err++;
    $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  function automatic logic [19:0] pte_addr(input logic [19:0] v);
    logic [31:0] a;
    a = 32'(PT_BASE) + 32'(v) * 32'd4;
    return a[19:0];
  endfunction

  function automatic logic [19:0] rand_vpn();
    case ($urandom_range(0, 3))
      0:       return 20'hFFFFF - 20'($urandom_range(0, 3));
      1:       return 20'($urandom_range(0, 15));
      default: return 20'($urandom);
    endcase
  endfunction

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic raise(input int s, input logic [19:0] v);
    logic [19:0] a;
    logic [31:0] e;
    exp_t        x;
    a = pte_addr(v);
    if (!pt.exists(a)) pt[a] = $urandom;
    e = pt[a];
    x.is_fault = ~e[31];
    x.vpn      = v;
    x.ppn      = e[7:0];
    if (s == 0) exp_q0.push_back(x);
    else        exp_q1.push_back(x);
    n_raised++;
    if (!e[31]) n_faults++;
    vpn_a[s]  = v;
    miss_a[s] = 1'b1;
    st[s]     = 1;
    age[s]    = 0;
  endtask

  // TLB side models: hold miss until served, drop it 0 or 1 cycle later, then cool down.
  always @(negedge clk) begin : drv
    logic served;
    int   hold;
    if (!rst) begin
      for (int s = 0; s < 2; s++) begin
        served = ((s == 0) ? itlb_write_en : dtlb_write_en) || (fault && (fault_is_d == (s == 1)));
        case (st[s])
          1: begin
            age[s]++;
            if (served) begin
              hold = (force_hold >= 0) ? force_hold : int'($urandom_range(0, 1));
              if (hold == 0) begin
                miss_a[s] = 1'b0;
                st[s]     = 3;
              end else begin
                st[s] = 2;
              end
            end else if (age[s] > 400) begin
              fail_now("service_timeout", age[s], 400);
              miss_a[s] = 1'b0;
              st[s]     = 0;
            end
          end
          2: begin
            miss_a[s] = 1'b0;
            st[s]     = 3;
          end
          3: st[s] = 0;
          default: if (gen_en && ($urandom_range(0, 3) == 0)) raise(s, rand_vpn());
        endcase
      end
    end
  end

  // Memory port model backed by the page table.
  initial begin : resp
    int   d;
    logic legit;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst && mem_req && !mem_hold) begin
        d = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
        for (int i = 0; i <= d; i++) begin
          if (i > 0) @(negedge clk);
          legit = ((st[0] == 1) && (mem_addr == pte_addr(vpn_a[0]))) ||
                  ((st[1] == 1) && (mem_addr == pte_addr(vpn_a[1])));
          check("mem_addr_legit", 32'(legit), 32'd1);
          check("mem_req_held", 32'(mem_req), 32'd1);
        end
        mem_ack   = 1'b1;
        mem_rdata = pt.exists(mem_addr) ? pt[mem_addr] : 32'h0;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        check("mem_req_drop", 32'(mem_req), 32'd0);
      end
    end
  end

  // Scoreboard monitor: every refill/fault pulse must match the oldest expectation of its side.
  always @(negedge clk) begin : mon
    exp_t x;
    int   side;
    if (!rst && (itlb_write_en || dtlb_write_en || fault)) begin
      check("pulse_onehot", 32'(itlb_write_en) + 32'(dtlb_write_en) + 32'(fault), 32'd1);
      side = itlb_write_en ? 0 : (dtlb_write_en ? 1 : (fault_is_d ? 1 : 0));
      if (((side == 0) && (exp_q0.size() == 0)) || ((side == 1) && (exp_q1.size() == 0))) begin
        fail_now("unexpected_pulse_side", side, -1);
      end else begin
        if (side == 0) x = exp_q0.pop_front();
        else           x = exp_q1.pop_front();
        check("is_fault", 32'(fault), 32'(x.is_fault));
        if (x.is_fault) begin
          check("fault_vpn", 32'(fault_vpn), 32'(x.vpn));
        end else begin
          check("write_vpn", 32'(write_vpn), 32'(x.vpn));
          check("write_ppn", 32'(write_ppn), 32'(x.ppn));
        end
        served_log.push_back(side);
      end
    end
  end

  task automatic wait_req();
    int n = 0;
    while (!mem_req && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    if (!mem_req) fail_now("mem_req_timeout", n, 50);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((st[0] == 0) && (st[1] == 0) && !busy) && (n < 1000));
    if (n >= 1000) fail_now("idle_timeout", n, 1000);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_itlb_we"}, 32'(itlb_write_en), 32'd0);
    check({tag, "_dtlb_we"}, 32'(dtlb_write_en), 32'd0);
    check({tag, "_write_vpn"}, 32'(write_vpn), 32'd0);
    check({tag, "_write_ppn"}, 32'(write_ppn), 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_fault_is_d"}, 32'(fault_is_d), 32'd0);
    check({tag, "_fault_vpn"}, 32'(fault_vpn), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_walk_cnt"}, 32'(walk_cnt), 32'd0);
    check({tag, "_fault_cnt"}, 32'(fault_cnt), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    miss_a[0] = 1'b0;
    miss_a[1] = 1'b0;
    vpn_a[0]  = 20'h0;
    vpn_a[1]  = 20'h0;
    st[0]     = 0;
    st[1]     = 0;
    age[0]    = 0;
    age[1]    = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    // D-side fill, ack two cycles after the request.
    pt[20'h1000C] = 32'h8000_0042;
    force_delay = 2;
    served_log.delete();
    raise(1, 20'h00003);
    wait_req();
    check("t1_mem_addr", 32'(mem_addr), 32'h1000C);
    wait_idle();
    check("t1_walk_cnt", 32'(walk_cnt), 32'd1);
    check("t1_pulses", 32'(served_log.size()), 32'd1);

    // D-side fault on an invalid PTE.
    pt[pte_addr(20'h00010)] = 32'h0000_00FF;
    force_delay = -1;
    served_log.delete();
    raise(1, 20'h00010);
    wait_idle();
    check("t2_fault_cnt", 32'(fault_cnt), 32'd1);
    check("t2_walk_cnt", 32'(walk_cnt), 32'd2);
    check("t2_fault_vpn", 32'(fault_vpn), 32'h00010);
    check("t2_fault_is_d", 32'(fault_is_d), 32'd1);
    check("t2_pulses", 32'(served_log.size()), 32'd1);

    // Simultaneous misses: I side first, then D.
    pt[pte_addr(20'h00020)] = 32'h8000_0011;
    pt[pte_addr(20'h00021)] = 32'h8000_0022;
    served_log.delete();
    raise(0, 20'h00020);
    raise(1, 20'h00021);
    wait_idle();
    check("t3_pulses", 32'(served_log.size()), 32'd2);
    if (served_log.size() == 2) begin
      check("t3_first_side", 32'(served_log[0]), 32'd0);
      check("t3_second_side", 32'(served_log[1]), 32'd1);
    end

    // Table address wraps modulo 2^20.
    raise(0, 20'hFFFFF);
    wait_req();
    check("t4_wrap_addr", 32'(mem_addr), 32'h0FFFC);
    wait_idle();

    // D miss held one cycle past its fill while I is pending.
    pt[pte_addr(20'h00030)] = 32'h8000_0033;
    pt[pte_addr(20'h00031)] = 32'h8000_0034;
    force_hold  = 1;
    force_delay = 2;
    served_log.delete();
    raise(1, 20'h00030);
    wait_req();
    raise(0, 20'h00031);
    wait_idle();
    check("t5_pulses", 32'(served_log.size()), 32'd2);
    if (served_log.size() == 2) begin
      check("t5_first_side", 32'(served_log[0]), 32'd1);
      check("t5_second_side", 32'(served_log[1]), 32'd0);
    end
    force_hold  = -1;
    force_delay = -1;
    check("dir_walk_cnt", 32'(walk_cnt), 32'(sat(n_raised)));
    check("dir_fault_cnt", 32'(fault_cnt), 32'(sat(n_faults)));

    // Randomized traffic on both sides.
    gen_en = 1'b1;
    repeat (3000) @(negedge clk);
    gen_en = 1'b0;
    wait_idle();
    check("rnd_walk_cnt", 32'(walk_cnt), 32'(sat(n_raised)));
    check("rnd_fault_cnt", 32'(fault_cnt), 32'(sat(n_faults)));
    check("rnd_q_empty", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

    // Reset mid-walk: mem_req drops asynchronously and a late ack is ignored.
    mem_hold = 1'b1;
    raise(1, 20'h00055);
    wait_req();
    @(negedge clk);
    #2;
    rst       = 1'b1;
    miss_a[0] = 1'b0;
    miss_a[1] = 1'b0;
    st[0]     = 0;
    st[1]     = 0;
    exp_q0.delete();
    exp_q1.delete();
    #1;
    check("rst_mem_req_async", 32'(mem_req), 32'd0);
    check("rst_busy_async", 32'(busy), 32'd0);
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'h8000_0077;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    check_reset_values("post_rst");
    @(negedge clk);
    check_reset_values("post_rst2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    fail_now("global_watchdog", 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
